// File: rtl/audio_sfx_scheduler.sv
// Sound-effect sequencer: fixed-priority arbitration (OVER > MISS > HIT) with preemption,
// each effect played as a short table of (tone half-period, duration ticks) steps.
module audio_sfx_scheduler #(
  parameter int TICK_DIV = 1_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_hit,
  input  logic        req_miss,
  input  logic        req_over,
  input  logic        en_music,
  output logic [19:0] sfx_tone,
  output logic        sfx_active,
  output logic [1:0]  cur_id,
  output logic        music_gate
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  // states: IDLE no effect | LOAD fetch step | PLAY tone out | GAP trailing silence
  typedef enum logic [1:0] {IDLE, LOAD, PLAY, GAP} state_t;

  state_t          state;
  logic [2:0]      pend;
  logic [1:0]      step;
  logic [5:0]      dur_cnt;
  logic [PW-1:0]   presc;
  logic [1:0]      hi_id;
  logic            tick;
  logic            start;
  logic [2:0]      clr;

  function automatic logic [19:0] step_tone(input logic [1:0] id, input logic [1:0] s);
    case ({id, s})
      4'b01_00: step_tone = 20'd47755;
      4'b01_01: step_tone = 20'd37908;
      4'b10_00: step_tone = 20'd113636;
      4'b10_01: step_tone = 20'd143266;
      4'b11_00: step_tone = 20'd127551;
      4'b11_01: step_tone = 20'd151515;
      4'b11_10: step_tone = 20'd190840;
      4'b11_11: step_tone = 20'd381679;
      default:  step_tone = 20'd0;
    endcase
  endfunction

  function automatic logic [5:0] step_dur(input logic [1:0] id, input logic [1:0] s);
    case ({id, s})
      4'b01_00, 4'b01_01: step_dur = 6'd3;
      4'b10_00:           step_dur = 6'd5;
      4'b11_11:           step_dur = 6'd30;
      default:            step_dur = 6'd10;
    endcase
  endfunction

  function automatic logic [1:0] last_step(input logic [1:0] id);
    last_step = (id == 2'd3) ? 2'd3 : 2'd1;
  endfunction

  always_comb begin
    hi_id = pend[2] ? 2'd3 : pend[1] ? 2'd2 : pend[0] ? 2'd1 : 2'd0;
    tick  = (presc == PW'(TICK_DIV - 1));
    start = 1'b0;
    case (state)
      IDLE:      start = (hi_id != 2'd0);
      GAP:       start = (hi_id != 2'd0) && ((hi_id >= cur_id) || tick);
      default:   start = (hi_id != 2'd0) && (hi_id >= cur_id);
    endcase
    clr = 3'b000;
    if (start) begin
      // starting OVER also discards any queued HIT/MISS
      case (hi_id)
        2'd3:    clr = 3'b111;
        2'd2:    clr = 3'b010;
        default: clr = 3'b001;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      pend       <= 3'b000;
      step       <= 2'd0;
      dur_cnt    <= 6'd0;
      presc      <= '0;
      sfx_tone   <= 20'd0;
      sfx_active <= 1'b0;
      cur_id     <= 2'd0;
    end else begin
      pend <= (pend & ~clr) | {req_over, req_miss, req_hit};
      if (start) begin
        state      <= LOAD;
        cur_id     <= hi_id;
        step       <= 2'd0;
        sfx_active <= 1'b1;
        presc      <= '0;
      end else begin
        case (state)
          IDLE: presc <= '0;
          LOAD: begin
            sfx_tone <= step_tone(cur_id, step);
            dur_cnt  <= step_dur(cur_id, step) - 6'd1;
            presc    <= '0;
            state    <= PLAY;
          end
          PLAY: begin
            presc <= tick ? '0 : presc + 1'b1;
            if (tick) begin
              if (dur_cnt == 6'd0) begin
                if (step == last_step(cur_id)) begin
                  state    <= GAP;
                  sfx_tone <= 20'd0;
                  presc    <= '0;
                end else begin
                  state <= LOAD;
                  step  <= step + 2'd1;
                end
              end else begin
                dur_cnt <= dur_cnt - 6'd1;
              end
            end
          end
          GAP: begin
            presc <= tick ? '0 : presc + 1'b1;
            if (tick) begin
              state      <= IDLE;
              cur_id     <= 2'd0;
              sfx_active <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign music_gate = en_music & ~sfx_active;

endmodule

// File: tb/tb_audio_sfx_scheduler.sv
// Scoreboard bench: stimulus pushes hand-computed output-change events; a negedge
// monitor pops one per observed change of (tone, id, active) and checks cycle and values.
module tb_audio_sfx_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_hit, req_miss, req_over, en_music;
  logic [19:0] sfx_tone;
  logic        sfx_active;
  logic [1:0]  cur_id;
  logic        music_gate;

  audio_sfx_scheduler #(.TICK_DIV(4)) dut (
    .clk(clk), .rst(rst), .req_hit(req_hit), .req_miss(req_miss), .req_over(req_over),
    .en_music(en_music), .sfx_tone(sfx_tone), .sfx_active(sfx_active), .cur_id(cur_id),
    .music_gate(music_gate)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [19:0] tone;
    logic [1:0]  id;
    logic        act;
  } ev_t;

  ev_t         q[$];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  bit          mon_en = 1'b0;
  logic        exp_act = 1'b0;
  logic [22:0] prev = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    ev_t e;
    if (!mon_en) begin
      exp_act = 1'b0;
    end else begin
      if (q.size() != 0 && q[0].cyc < cyc) begin
        e = q.pop_front();
        checks++; errors++;
        exp_act = e.act;
        $display("FAIL missing_event: expected change at cyc=%0d tone=%0d id=%0d act=%0d, not seen by cyc=%0d",
                 e.cyc, e.tone, e.id, e.act, cyc);
      end
      if ({sfx_tone, cur_id, sfx_active} !== prev) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_change cyc=%0d: got tone=%0d id=%0d act=%0d, required no change",
                   cyc, sfx_tone, cur_id, sfx_active);
        end else begin
          e = q.pop_front();
          exp_act = e.act;
          if (e.cyc != cyc || e.tone !== sfx_tone || e.id !== cur_id || e.act !== sfx_active) begin
            errors++;
            $display("FAIL event: got cyc=%0d tone=%0d id=%0d act=%0d, required cyc=%0d tone=%0d id=%0d act=%0d",
                     cyc, sfx_tone, cur_id, sfx_active, e.cyc, e.tone, e.id, e.act);
          end
        end
      end
      checks++;
      if (music_gate !== (en_music & ~exp_act)) begin
        errors++;
        $display("FAIL music_gate cyc=%0d: got %0b, required %0b", cyc, music_gate, en_music & ~exp_act);
      end
    end
    prev = {sfx_tone, cur_id, sfx_active};
  end

  task automatic expect_ev(input int c, input int tone, input int id, input bit act);
    ev_t e;
    e.cyc = c; e.tone = 20'(tone); e.id = 2'(id); e.act = act;
    q.push_back(e);
  endtask

  // HIT from its LOAD cycle L, entered with the tone already silent
  task automatic push_hit(input int L);
    expect_ev(L,      0,     1, 1);
    expect_ev(L + 1,  47755, 1, 1);
    expect_ev(L + 14, 37908, 1, 1);
    expect_ev(L + 26, 0,     1, 1);
    expect_ev(L + 30, 0,     0, 0);
  endtask

  // OVER steps after its LOAD cycle L (the LOAD-cycle event is pushed by the caller)
  task automatic push_over(input int L, input bit to_idle);
    expect_ev(L + 1,   127551, 3, 1);
    expect_ev(L + 42,  151515, 3, 1);
    expect_ev(L + 83,  190840, 3, 1);
    expect_ev(L + 124, 381679, 3, 1);
    expect_ev(L + 244, 0,      3, 1);
    if (to_idle) expect_ev(L + 248, 0, 0, 0);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic pulse_now(input logic [2:0] oms);
    {req_over, req_miss, req_hit} = oms;
    @(posedge clk); #1;
    {req_over, req_miss, req_hit} = 3'b000;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  initial begin
    int t, p, r, L;
    rst = 1'b0; en_music = 1'b1;
    {req_over, req_miss, req_hit} = 3'b000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tone", 32'(sfx_tone), 0);
    chk("rst_active", 32'(sfx_active), 0);
    chk("rst_id", 32'(cur_id), 0);
    chk("rst_gate", 32'(music_gate), 1);
    @(posedge clk); #1;
    rst = 1'b1; mon_en = 1'b1;

    // single HIT
    t = cyc + 5; wait_until(t);
    pulse_now(3'b001); push_hit(t + 2);
    wait_until(t + 40);

    // simultaneous HIT+MISS, music disabled
    en_music = 1'b0;
    t = cyc + 2; wait_until(t);
    pulse_now(3'b011);
    expect_ev(t + 2, 0, 2, 1); expect_ev(t + 3, 113636, 2, 1);
    expect_ev(t + 24, 143266, 2, 1); expect_ev(t + 64, 0, 2, 1);
    push_hit(t + 68);
    wait_until(t + 105);
    en_music = 1'b1;

    // OVER (with a repeated HIT) preempts HIT step 0
    t = cyc + 3; wait_until(t);
    pulse_now(3'b001);
    expect_ev(t + 2, 0, 1, 1); expect_ev(t + 3, 47755, 1, 1);
    p = t + 5; wait_until(p);
    pulse_now(3'b101);
    expect_ev(p + 2, 47755, 3, 1); push_over(p + 2, 1'b1);
    wait_until(p + 275);

    // HIT during OVER step 2 waits for OVER and its GAP
    t = cyc + 2; wait_until(t);
    pulse_now(3'b100);
    expect_ev(t + 2, 0, 3, 1); push_over(t + 2, 1'b0);
    wait_until(t + 90);
    pulse_now(3'b001); push_hit(t + 250);
    wait_until(t + 290);

    // MISS retrigger plus three collapsed HIT requests
    t = cyc + 2; wait_until(t);
    pulse_now(3'b010);
    expect_ev(t + 2, 0, 2, 1); expect_ev(t + 3, 113636, 2, 1); expect_ev(t + 24, 143266, 2, 1);
    wait_until(t + 8);  pulse_now(3'b001);
    wait_until(t + 14); pulse_now(3'b001);
    wait_until(t + 20); pulse_now(3'b001);
    r = t + 30; wait_until(r);
    pulse_now(3'b010);
    L = r + 2;
    expect_ev(L + 1, 113636, 2, 1); expect_ev(L + 22, 143266, 2, 1);
    expect_ev(L + 62, 0, 2, 1); push_hit(L + 66);
    wait_until(L + 140);

    // reset mid-OVER
    t = cyc + 2; wait_until(t);
    pulse_now(3'b100);
    expect_ev(t + 2, 0, 3, 1); expect_ev(t + 3, 127551, 3, 1);
    wait_until(t + 20);
    chk("pre_rst_queue", 32'(q.size()), 0);
    mon_en = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("midrst_tone", 32'(sfx_tone), 0);
    chk("midrst_active", 32'(sfx_active), 0);
    chk("midrst_id", 32'(cur_id), 0);
    chk("midrst_gate", 32'(music_gate), 1);
    @(posedge clk); #1;
    pulse_now(3'b111);
    @(posedge clk); #1;
    rst = 1'b1; mon_en = 1'b1;
    wait_until(cyc + 20);

    chk("final_queue_empty", 32'(q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
